sha3_absorb_feeder: RTL
=======================

# sha3_absorb_feeder

Streaming front end for the `keccak` core. It accepts a message as a byte stream with valid/ready handshaking and applies SHA-3 padding in hardware. It assembles rate-sized blocks and drives `keccak`'s `reset`, `enable` and `message` inputs with the same schedule the SHA-3 benches apply in software. It sits between a byte source (DMA/UART) and `keccak #(d, 6, s)`, and flags when `digest` is valid.

## Interface
- `d`, 256: digest length; 224, 256, 384 or 512.
- `s`, 24: keccak pipeline stages; an integer divisor of 24. Each block is held for `s` cycles.
- `r` (localparam): rate, `1600 - 2*d`; `NB = r/8` bytes per block.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_byte`  in  8  message byte.
- `in_last`  in  1  final byte of the message; every message is ≥1 byte.
- `core_reset`  out  1  to keccak `reset`.
- `core_enable`  out  1  to keccak `enable`.
- `core_message`  out  r  to keccak `message`.
- `digest_valid`  out  1  one-cycle pulse; keccak `digest` is final and holds until the next message starts.

## Operation
- Byte order: the first byte of a block lands in `[r-1:r-8]`. The assembly register shifts left by 8 per byte, and the new byte enters `[7:0]`.
- Assembler FSM:
  - IDLE: `in_ready=1`. On an accepted byte, go to FILL and pulse `core_reset` for that cycle.
  - FILL: accept bytes and count them in `cnt` (0..NB). On `in_last`, go to PAD.
  - PAD: `in_ready=0`. Insert one pad byte per cycle until the block is full, then go to WAIT_DONE.
  - WAIT_DONE: no bytes accepted. Go to IDLE when `digest_valid` pulses.
- Pad bytes: the first pad byte is 8'h06, bytes at block position NB-1 are 8'h80, and a byte that is both is 8'h86. Any other pad byte is 8'h00.
- When the message length is an exact multiple of NB, a whole extra block `06 00…00 80` follows.
- Block full (`cnt==NB`): the assembler holds and `in_ready=0` until the issuer takes the block. Hand-off clears `cnt` in the same cycle.
- Issuer:
  - Registers `core_message` and a stage counter `sc` (0..s-1).
  - A block transfers when it is full and either the issuer is idle or `sc==s-1`. On transfer, `core_message` loads, `sc` goes to 0 and `core_enable` goes to 1.
  - `core_enable` stays high continuously across back-to-back blocks.
  - If `sc==s-1` and no full block is pending, `sc` holds and `core_enable` stays high; this stall can only occur mid-message.
- After the padded final block has had `sc==s-1`: the next cycle has `core_enable=0` and `digest_valid=1`.
- Reset values: `in_ready=0`, `core_reset=1`, `core_enable=0`, `core_message=0`, `digest_valid=0`, FSM in IDLE, counters 0.
- Reset mid-operation aborts everything; the message is discarded.

## Timing
- Throughput: 1 byte/cycle in FILL, 1 pad byte/cycle in PAD.
- The next block assembles while the current one is absorbed. It stalls only if NB < s, which is never true for legal `d`/`s`.
- Block issue is 1 cycle after the cycle in which `cnt` reaches NB.
- Digest latency: `digest_valid` asserts `s` cycles after the final block loads into `core_message`.
- `in_valid` and `in_last` are sampled only when `in_ready=1`. A dropped `in_valid` in FILL simply pauses the stream.
- `core_reset` pulses for exactly 1 cycle per message, always at least NB cycles before the first `core_enable`.

## Structure
- `sha3_pkg`:
  - constants `SHA3_PAD_FIRST=8'h06`, `SHA3_PAD_LAST=8'h80`, `KECCAK_WIDTH=1600`;
  - function `rate(d)`;
  - enum `feeder_state_t` (IDLE, FILL, PAD, WAIT_DONE).
- Sub-module `sha3_block_assembler`: shift register, `cnt` and pad insertion; it presents `full` and the assembled block.
- Top level holds the issuer counter and the FSM.

## Test plan
- Input "abc" with `d=256`, `s=24` -> one block, `digest_valid` once. Required digest: 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 135-byte message with `d=256` (NB=136) -> the single pad byte is 8'h86. The digest matches `openssl dgst -sha3-256`.
- 136-byte message with `d=256` -> two blocks; the second is exactly `06 00…00 80`. The digest matches openssl.
- 300-byte message with `d=512`, `s=4` (NB=72), `in_valid` randomly gapped -> 5 blocks, continuous `core_enable`, digest matches openssl.
- `reset` asserted mid-FILL, then "abc" sent -> outputs at reset values on the next cycle, and the "abc" digest is correct.
- Two back-to-back messages -> `core_reset` pulses on the first byte of each message, and each digest matches.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants, rate helper and feeder state encoding for the SHA-3 absorb front end.
package sha3_pkg;

    localparam int         KECCAK_WIDTH   = 1600;
    localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
    localparam logic [7:0] SHA3_PAD_LAST  = 8'h80;

    function automatic int rate(input int d);
        return KECCAK_WIDTH - 2 * d;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        WAIT_DONE
    } feeder_state_t;

endpackage

// File: rtl/sha3_block_assembler.sv
// Shifts message and pad bytes into a rate-sized block; first byte ends up in the top byte lane.
module sha3_block_assembler
    import sha3_pkg::*;
#(
    parameter  int R  = 1088,
    localparam int NB = R / 8,
    localparam int CW = $clog2(NB + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_byte,
    input  logic [7:0]   data,
    input  logic         wr_pad,
    input  logic         take,
    output logic         full,
    output logic         last_slot,
    output logic [R-1:0] block
);

    logic [R-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          pad_started;
    logic [7:0]    pad_byte;

    assign full      = (cnt == CW'(NB));
    assign last_slot = (cnt == CW'(NB - 1));
    assign block     = shreg;

    // A single pad byte that is both first and last merges to 8'h86.
    always_comb begin
        pad_byte = pad_started ? 8'h00 : SHA3_PAD_FIRST;
        if (last_slot) begin
            pad_byte = pad_byte | SHA3_PAD_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg       <= '0;
            cnt         <= '0;
            pad_started <= 1'b0;
        end else begin
            if (take) begin
                cnt <= '0;
            end else if (!full && (wr_byte || wr_pad)) begin
                shreg <= {shreg[R-9:0], (wr_byte ? data : pad_byte)};
                cnt   <= cnt + 1'b1;
            end
            if (wr_byte) begin
                pad_started <= 1'b0;
            end else if (wr_pad && !full) begin
                pad_started <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha3_absorb_feeder.sv
// Byte-stream front end for keccak: assembles padded rate blocks and sequences reset/enable.
//   state     | meaning
//   IDLE      | waiting for the first byte of a message
//   FILL      | accepting message bytes
//   PAD       | inserting pad bytes until the final block is full
//   WAIT_DONE | final block absorbing, waiting for digest_valid
module sha3_absorb_feeder
    import sha3_pkg::*;
#(
    parameter  int d = 256,
    parameter  int s = 24,
    localparam int r = rate(d)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic         core_reset,
    output logic         core_enable,
    output logic [r-1:0] core_message,
    output logic         digest_valid
);

    localparam int SCW = (s > 1) ? $clog2(s) : 1;

    feeder_state_t  state, state_nx;
    logic           rst_q;
    logic [SCW-1:0] sc;
    logic           final_q;
    logic           full, last_slot, wr_byte, wr_pad, take;
    logic [r-1:0]   block;

    sha3_block_assembler #(.R(r)) u_asm (
        .clk       (clk),
        .reset     (reset),
        .wr_byte   (wr_byte),
        .data      (in_byte),
        .wr_pad    (wr_pad),
        .take      (take),
        .full      (full),
        .last_slot (last_slot),
        .block     (block)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rst_q <= 1'b1;
        end else begin
            state <= state_nx;
            rst_q <= 1'b0;
        end
    end

    // rst_q keeps in_ready low and core_reset high for the cycle right after reset.
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        core_reset = rst_q;
        wr_byte    = 1'b0;
        wr_pad     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst_q;
                if (in_valid && in_ready) begin
                    wr_byte    = 1'b1;
                    core_reset = 1'b1;
                    state_nx   = in_last ? PAD : FILL;
                end
            end
            FILL: begin
                in_ready = !full;
                if (in_valid && in_ready) begin
                    wr_byte = 1'b1;
                    if (in_last) state_nx = PAD;
                end
            end
            PAD: begin
                if (!full) begin
                    wr_pad = 1'b1;
                    if (last_slot) state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (digest_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign take = full && (!core_enable || (sc == SCW'(s - 1)));

    // A block handed over while in WAIT_DONE is necessarily the padded final block.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_message <= '0;
            core_enable  <= 1'b0;
            sc           <= '0;
            final_q      <= 1'b0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            if (take) begin
                core_message <= block;
                core_enable  <= 1'b1;
                sc           <= '0;
                final_q      <= (state == WAIT_DONE);
            end else if (core_enable) begin
                if (sc != SCW'(s - 1)) begin
                    sc <= sc + 1'b1;
                end else if (final_q) begin
                    core_enable  <= 1'b0;
                    digest_valid <= 1'b1;
                    final_q      <= 1'b0;
                    sc           <= '0;
                end
            end
        end
    end

endmodule
